// File: rtl/mul_pkg.sv
// Shared definitions for units that use the go/over handshake: state encoding and default operand width.
package mul_pkg;

   localparam int unsigned MUL_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath: multiplicand/multiplier shift registers, accumulator adder and iteration counter.
module mul_datapath
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic                     step,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   output logic [2*WIDTH-1:0]       acc_next,
   output logic [$clog2(WIDTH):0]   count,
   output logic                     mplier_zero
);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mplier;

   assign acc_next = mplier[0] ? acc + mcand : acc;

   // Reports the multiplier as it will be after the current step, so the
   // controller can leave RUN on the same edge that consumes the last set bit.
   assign mplier_zero = ((mplier >> 1) == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
      end else if (load) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         count  <= '0;
      end else if (step) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mul_shift_add.sv
// Sequential unsigned shift-add multiplier with go/over handshake.
// Optional build macro MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module mul_shift_add
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 go,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic                 over
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

`ifdef MUL_EARLY_TERM_EN
   localparam bit EARLY_TERM = 1'b1;
`else
   localparam bit EARLY_TERM = 1'b0;
`endif

   state_t              state;
   state_t              next_state;
   logic                load;
   logic                step;
   logic                last;
   logic [2*WIDTH-1:0]  acc_next;
   logic [CW-1:0]       count;
   logic                mplier_zero;

   // Operands are captured on the go-accepting edge, so the values seen in
   // LOAD are those present when go was sampled.
   assign load = (state == IDLE) && go;
   assign step = (state == RUN);
   assign last = (count == CW'(WIDTH - 1)) || (EARLY_TERM && mplier_zero);

   mul_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .step        (step),
      .a           (a),
      .b           (b),
      .acc_next    (acc_next),
      .count       (count),
      .mplier_zero (mplier_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: if (go) next_state = LOAD;
         LOAD: next_state = RUN;
         RUN:  if (last) next_state = DONE;
         DONE: if (!go) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         product <= '0;
      end else if ((state == RUN) && last) begin
         product <= acc_next;
      end
   end

   assign busy = (state == LOAD) || (state == RUN);
   assign over = (state == DONE);

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench for mul_shift_add: directed corner cases plus random operands against an arithmetic model.
module tb_mul_shift_add;

   localparam int unsigned W = 8;

   logic           clk;
   logic           reset;
   logic           go;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [2*W-1:0] product;
   logic           busy;
   logic           over;

   int vectors;
   int miscompares;

   mul_shift_add #(
      .WIDTH (W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .go      (go),
      .a       (a),
      .b       (b),
      .product (product),
      .busy    (busy),
      .over    (over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint observed, input longint expected);
      vectors++;
      if (observed != expected) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Edges from the go-sampling edge (counted as 1) until over is seen.
   function automatic int exp_latency(input logic [W-1:0] bv);
`ifdef MUL_EARLY_TERM_EN
      int p;
      p = 0;
      for (int i = 0; i < int'(W); i++) if (bv[i]) p = i + 1;
      return 2 + ((p < 1) ? 1 : p);
`else
      return int'(W) + 2;
`endif
   endfunction

   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit pulse);
      int             lat;
      logic [2*W-1:0] prev;
      longint         expected;
      expected = longint'(ta) * longint'(tb_v);
      @(negedge clk);
      a    = ta;
      b    = tb_v;
      go   = 1'b1;
      prev = product;
      lat  = 0;
      while (!over && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            check("busy_after_accept", busy, 1);
            a = W'($urandom);
            b = W'($urandom);
            if (pulse) go = 1'b0;
         end
         if (!over) check("product_retained", product, prev);
      end
      check("latency", lat, exp_latency(tb_v));
      check("product", product, expected);
      check("busy_in_done", busy, 0);
      if (pulse) begin
         @(posedge clk);
         #1;
         check("over_one_cycle", over, 0);
      end else begin
         repeat (2) @(posedge clk);
         #1;
         check("over_held", over, 1);
         check("product_held", product, expected);
         go = 1'b0;
         @(posedge clk);
         #1;
         check("over_drop", over, 0);
         check("busy_idle", busy, 0);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset = 1'b1;
      go    = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_product", product, 0);
      check("reset_busy", busy, 0);
      check("reset_over", over, 0);
      @(negedge clk);
      reset = 1'b0;

      do_op(8'd13, 8'd11, 1'b0);
      do_op(8'd255, 8'd255, 1'b0);
      do_op(8'd0, 8'd200, 1'b0);
      do_op(8'd200, 8'd0, 1'b0);

      // Reset during the 4th RUN cycle of 7*9
      @(negedge clk);
      a  = 8'd7;
      b  = 8'd9;
      go = 1'b1;
      repeat (5) @(posedge clk);
      #3;
      check("pre_reset_busy", busy, 1);
      reset = 1'b1;
      #1;
      check("async_reset_product", product, 0);
      check("async_reset_over", over, 0);
      check("async_reset_busy", busy, 0);
      @(negedge clk);
      go    = 1'b0;
      reset = 1'b0;
      do_op(8'd7, 8'd9, 1'b0);

      do_op(8'd6, 8'd7, 1'b1);
      do_op(8'd3, 8'd5, 1'b0);
      do_op(8'd9, 8'd9, 1'b0);
      do_op(8'd1, 8'd128, 1'b1);

      for (int i = 0; i < 25; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
